// File: rtl/fifo_pkg.sv
// Shared definitions for the width-converting FIFO controller:
// the read-half state encoding and the reset values of pointers and flags.
package fifo_pkg;

    // Which half of the entry at r_addr is presented to the reader.
    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_t;

    // Reset values. Pointers reset to all-zero whatever their width,
    // so the pointer constant is a single replicated bit.
    localparam logic  RST_PTR_BIT = 1'b0;
    localparam half_t RST_HALF    = HALF_LO;
    localparam logic  RST_EMPTY   = 1'b1;
    localparam logic  RST_FULL    = 1'b0;

    // Advance the read-half state by one accepted pop.
    function automatic half_t next_half(input half_t cur);
        half_t nxt;
        case (cur)
            HALF_LO: nxt = HALF_HI;
            HALF_HI: nxt = HALF_LO;
            default: nxt = RST_HALF;
        endcase
        return nxt;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ctrl_if.sv
// Handshake and register-file control bundle of the FIFO controller.
// With FIFO_CTRL_COUNT_EN defined the bundle also carries the
// unread half-word count.
interface fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 2
);

    logic                  wr;
    logic                  rd;
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  half_sel;
    logic                  empty;
    logic                  full;
`ifdef FIFO_CTRL_COUNT_EN
    logic [ADDR_WIDTH+1:0] count;
`endif

    // User side: issues push/pop requests, observes pointers and flags.
    modport master (
        output wr,
        output rd,
        input  w_en,
        input  w_addr,
        input  r_addr,
        input  half_sel,
        input  empty,
        input  full
`ifdef FIFO_CTRL_COUNT_EN
        , input count
`endif
    );

    // Controller side.
    modport slave (
        input  wr,
        input  rd,
        output w_en,
        output w_addr,
        output r_addr,
        output half_sel,
        output empty,
        output full
`ifdef FIFO_CTRL_COUNT_EN
        , output count
`endif
    );

endinterface : fifo_ctrl_if

// File: rtl/fifo_ctrl_wrap_ctr.sv
// Modulo-2**WIDTH counter with synchronous active-high reset and an
// increment enable. Used for both FIFO pointers; wrap-around is the
// natural overflow of the register.
module wrap_ctr
    import fifo_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_r;

    // Pointer register: clears on reset, steps by one when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= {WIDTH{RST_PTR_BIT}};
        end else if (inc) begin
            value_r <= value_r + WIDTH'(1'b1);
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule : wrap_ctr

// File: rtl/fifo_ctrl.sv
// Control block of a width-converting FIFO: one 2*DATA_WIDTH entry is
// written per push and drained as two DATA_WIDTH halves, low half first.
// Owns the write/read pointers, the half-select FSM and the full/empty
// flags. Optional feature macro: FIFO_CTRL_COUNT_EN adds a registered
// count of unread half-words (2*entries - half_sel).
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    fifo_ctrl_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C      = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ENTRY_ZERO_C = {(ADDR_WIDTH+1){1'b0}};

    half_t                 half_r;
    half_t                 half_nxt_s;
    logic [ADDR_WIDTH:0]   entries_r;
    logic [ADDR_WIDTH:0]   entries_nxt_s;
    logic                  empty_r;
    logic                  full_r;
    logic                  empty_nxt_s;
    logic                  full_nxt_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  pop_done_s;
    logic [ADDR_WIDTH-1:0] w_addr_s;
    logic [ADDR_WIDTH-1:0] r_addr_s;

    // Requests are qualified by the registered (pre-edge) flags, so a
    // push at full is dropped even when the same edge frees an entry.
    assign push_s = bus.wr & ~full_r;
    assign pop_s  = bus.rd & ~empty_r;

    // Read-half FSM next state; leaving HALF_HI completes an entry.
    always_comb begin
        half_nxt_s = half_r;
        pop_done_s = 1'b0;
        case (half_r)
            HALF_LO: begin
                if (pop_s) begin
                    half_nxt_s = next_half(half_r);
                end else begin
                    half_nxt_s = half_r;
                end
            end
            HALF_HI: begin
                if (pop_s) begin
                    half_nxt_s = next_half(half_r);
                    pop_done_s = 1'b1;
                end else begin
                    half_nxt_s = half_r;
                end
            end
            default: begin
                half_nxt_s = RST_HALF;
                pop_done_s = 1'b0;
            end
        endcase
    end

    // Read-half FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            half_r <= RST_HALF;
        end else begin
            half_r <= half_nxt_s;
        end
    end

    // Entry occupancy: a half-read entry stays occupied until its high
    // half is popped, so only a completed entry is subtracted.
    always_comb begin
        entries_nxt_s = entries_r
                      + {{ADDR_WIDTH{1'b0}}, push_s}
                      - {{ADDR_WIDTH{1'b0}}, pop_done_s};
        empty_nxt_s   = (entries_nxt_s == ENTRY_ZERO_C);
        full_nxt_s    = (entries_nxt_s == DEPTH_C);
    end

    // Occupancy counter and registered flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            entries_r <= ENTRY_ZERO_C;
            empty_r   <= RST_EMPTY;
            full_r    <= RST_FULL;
        end else begin
            entries_r <= entries_nxt_s;
            empty_r   <= empty_nxt_s;
            full_r    <= full_nxt_s;
        end
    end

    wrap_ctr #(
        .WIDTH (ADDR_WIDTH)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push_s),
        .value (w_addr_s)
    );

    wrap_ctr #(
        .WIDTH (ADDR_WIDTH)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_done_s),
        .value (r_addr_s)
    );

`ifdef FIFO_CTRL_COUNT_EN
    logic [ADDR_WIDTH+1:0] count_r;
    logic [ADDR_WIDTH+1:0] count_nxt_s;

    // Half-word count: a push adds two halves, every accepted pop removes one.
    always_comb begin
        count_nxt_s = count_r
                    + {{ADDR_WIDTH{1'b0}}, push_s, 1'b0}
                    - {{(ADDR_WIDTH+1){1'b0}}, pop_s};
    end

    // Half-word count register, updated on the same edge as the flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {(ADDR_WIDTH+2){1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign bus.count = count_r;
`endif

    // The write enable is the only combinational output.
    assign bus.w_en     = push_s;
    assign bus.w_addr   = w_addr_s;
    assign bus.r_addr   = r_addr_s;
    assign bus.half_sel = (half_r == HALF_HI);
    assign bus.empty    = empty_r;
    assign bus.full     = full_r;

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with ADDR_WIDTH=2: a table of
// directed vectors followed by a model-driven random run. Expected
// post-edge state is queued when a vector is driven and popped after
// the edge to be compared with the controller outputs.
module tb_fifo_ctrl;

    localparam int AW = 2;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       rst;
        logic       exp_wen;
        logic [1:0] exp_waddr;
        logic [1:0] exp_raddr;
        logic       exp_half;
        logic       exp_empty;
        logic       exp_full;
        logic [3:0] exp_count;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    vec_t tbl[$];
    vec_t exp_q[$];

    // reference model state for the random run
    int m_w, m_r, m_half, m_ent;

    fifo_ctrl_if #(.ADDR_WIDTH(AW)) dut_if ();

    fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic wr, input logic rd, input logic rst,
                                input logic wen, input int wa, input int ra,
                                input logic hs, input logic em, input logic fu,
                                input int cnt);
        vec_t v;
        v.wr = wr; v.rd = rd; v.rst = rst; v.exp_wen = wen;
        v.exp_waddr = 2'(wa); v.exp_raddr = 2'(ra); v.exp_half = hs;
        v.exp_empty = em; v.exp_full = fu; v.exp_count = 4'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int idx);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one vector, check w_en before the edge, check state after it.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        dut_if.wr = v.wr;
        dut_if.rd = v.rd;
        reset     = v.rst;
        #1;
        chk("w_en", int'(dut_if.w_en), int'(v.exp_wen), idx);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("w_addr",   int'(dut_if.w_addr),   int'(e.exp_waddr), idx);
        chk("r_addr",   int'(dut_if.r_addr),   int'(e.exp_raddr), idx);
        chk("half_sel", int'(dut_if.half_sel), int'(e.exp_half),  idx);
        chk("empty",    int'(dut_if.empty),    int'(e.exp_empty), idx);
        chk("full",     int'(dut_if.full),     int'(e.exp_full),  idx);
`ifdef FIFO_CTRL_COUNT_EN
        chk("count",    int'(dut_if.count),    int'(e.exp_count), idx);
`endif
    endtask

    initial begin
        vec_t v;
        int   wen;
        int   pop;
        n_cmp  = 0;
        n_fail = 0;
        dut_if.wr = 1'b0;
        dut_if.rd = 1'b0;
        reset     = 1'b1;

        //         wr    rd    rst   w_en  wa ra hs    empty full  cnt
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0)); // reset
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0)); // idle
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0)); // rd on empty x3
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 2)); // 4 pushes
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 4));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 6));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 8));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 8)); // 5th wr dropped
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 7)); // low half
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 6)); // high half frees
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b1, 8)); // refill
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 1'b1, 7)); // full, half_sel=1
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0, 1'b0, 6)); // push dropped, pop frees
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 1'b1, 1'b0, 1'b0, 5)); // drain, r_addr wraps
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1, 3, 1'b0, 1'b0, 1'b0, 4));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1, 3, 1'b1, 1'b0, 1'b0, 3));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 2));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b1, 1'b0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b1, 1'b0, 0)); // rd on empty
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0, 2)); // wr+rd from empty
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 3, 1, 1'b0, 1'b0, 1'b0, 4)); // second push
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 3, 1, 1'b1, 1'b0, 1'b0, 3)); // one pop
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 0)); // reset beats wr
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0)); // fresh FIFO
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 2));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 3)); // wr+rd on HALF_LO

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        // Model state after the table: w=2, r=0, half=1, two entries.
        m_w = 2; m_r = 0; m_half = 1; m_ent = 2;
        for (int i = 0; i < 400; i++) begin
            v.wr  = 1'($urandom_range(0, 1));
            v.rd  = 1'($urandom_range(0, 1));
            v.rst = ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0;
            wen   = (v.wr == 1'b1 && m_ent != 4) ? 1 : 0;
            v.exp_wen = 1'(wen);
            if (v.rst == 1'b1) begin
                m_w = 0; m_r = 0; m_half = 0; m_ent = 0;
            end else begin
                pop = (v.rd == 1'b1 && m_ent != 0) ? 1 : 0;
                if (wen == 1) begin
                    m_w = (m_w + 1) % 4;
                    m_ent++;
                end
                if (pop == 1) begin
                    if (m_half == 1) begin
                        m_r = (m_r + 1) % 4;
                        m_ent--;
                        m_half = 0;
                    end else begin
                        m_half = 1;
                    end
                end
            end
            v.exp_waddr = 2'(m_w);
            v.exp_raddr = 2'(m_r);
            v.exp_half  = 1'(m_half);
            v.exp_empty = (m_ent == 0) ? 1'b1 : 1'b0;
            v.exp_full  = (m_ent == 4) ? 1'b1 : 1'b0;
            v.exp_count = 4'(2 * m_ent - m_half);
            step(v, 1000 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fifo_ctrl

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control block for a width-converting FIFO built around the team's register file: one full-width entry (2×DATA_WIDTH) is written per push, and each entry is drained as two DATA_WIDTH halves, low half first. It owns the write/read pointers, the half-select, and the full/empty flags. It drives the register file's write enable, write address, read address and half-select.

## Interface
- ADDR_WIDTH, default 2, address width of the register file; depth = 2**ADDR_WIDTH entries.
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  push request; entry data is presented to the register file by the user.
- rd  input  1  pop request for one half-word.
- w_en  output  1  register file write enable = wr & ~full (combinational).
- w_addr  output  ADDR_WIDTH  write pointer (registered).
- r_addr  output  ADDR_WIDTH  read pointer (registered).
- half_sel  output  1  0 = low half of r_addr entry, 1 = high half (registered).
- empty  output  1  no unread half-words (registered).
- full  output  1  all 2**ADDR_WIDTH entries occupied (registered).
- count  output  ADDR_WIDTH+2  unread half-words; present only with FIFO_CTRL_COUNT_EN.

## Operation
- Push accepted iff wr & ~full at the edge: write to w_addr, then w_addr increments modulo 2**ADDR_WIDTH.
- Pop accepted iff rd & ~empty. The read-half FSM has two states:
  - HALF_LO (half_sel=0) → HALF_HI.
  - HALF_HI (half_sel=1) → HALF_LO, and r_addr increments modulo 2**ADDR_WIDTH, which frees the entry.
- Flags are evaluated on pre-edge values. wr when full is dropped and w_en stays 0, even if a simultaneous pop frees an entry that cycle. rd when empty is ignored and no state changes.
- Push and pop in the same cycle:
  - Both are accepted, subject to the individual rules above.
  - Entries stay constant if the pop completes an entry (HALF_HI). Otherwise they grow by one.
- Entry occupancy is tracked internally with one extra pointer bit, or an equivalent entry counter.
  - empty = (entries==0).
  - full = (entries==2**ADDR_WIDTH).
  - A partially read entry (half_sel=1) still counts as occupied.
- Wrap-around of both pointers is silent modulo arithmetic. There is no overflow or underflow state.

## Timing
- Reset values: w_addr=0, r_addr=0, half_sel=0, empty=1, full=0, count=0.
- Reset has priority over wr/rd in the same cycle. Reset mid-operation discards all contents, and the next cycle behaves as a fresh FIFO.
- Write latency:
  - Push at edge N → empty deasserts after edge N.
  - Data is visible on the register file's asynchronous read in the cycle after N.
- Pop latency: half_sel and r_addr update after the accepting edge, so the next half is readable the following cycle. Sustained throughput is one half-word per cycle.
- Full asserts after the edge that accepts the 2**ADDR_WIDTH-th outstanding push. It deasserts after the edge that pops a HALF_HI.
- w_en is the only combinational output.

## Configuration
- FIFO_CTRL_COUNT_EN defined:
  - count port and counter are present; count = 2·entries − half_sel.
  - Range is 0..2**(ADDR_WIDTH+1).
  - count updates on the same edge as the flags.
- Not defined: the count port and its logic are absent, and all other behaviour is identical.

## Structure
- Shared package fifo_pkg:
  - typedef enum logic {HALF_LO, HALF_HI} half_t.
  - Reset-value constants for pointers and flags.
- One natural sub-module, wrap_ctr: a parameterized modulo-2**ADDR_WIDTH counter with synchronous reset and increment enable. It is instantiated twice, once for the write pointer and once for the read pointer.
- The FSM and flag logic live in fifo_ctrl.

## Test plan
All scenarios use ADDR_WIDTH=2 and FIFO_CTRL_COUNT_EN defined.
- Reset, then idle, then rd=1 for 3 cycles → empty=1, r_addr=0, half_sel=0, count=0 throughout.
- 4 pushes → w_addr steps 1,2,3,0; full=1 after the 4th edge; count=8; a 5th wr gives w_en=0 and no change.
- From full, pop one half-word → half_sel=1, full stays 1, count=7. Pop again → r_addr=1, full=0, count=6.
- From empty, wr=1 and rd=1 in the same cycle → only the push is accepted: empty=0, half_sel=0, count=2.
- At full with half_sel=1, wr=1 and rd=1 together → push dropped, w_en=0; pop frees the entry, giving full=0 and count=6.
- After 2 pushes and 1 pop, assert reset with wr=1 → all outputs return to reset values next cycle, and the push is ignored.
